// File: rtl/ddr2_local_port_arbiter_if.sv
// rtl/ddr2_local_port_arbiter_if.sv - user-port and controller-local signal bundle for the DDR2 port arbiter
interface ddr2_local_port_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 64,
  parameter int BE_W      = 8,
  parameter int SIZE_W    = 4
);
  logic [NUM_PORTS*ADDR_W-1:0] p_address;
  logic [NUM_PORTS-1:0]        p_read_req;
  logic [NUM_PORTS-1:0]        p_write_req;
  logic [NUM_PORTS-1:0]        p_burstbegin;
  logic [NUM_PORTS*SIZE_W-1:0] p_size;
  logic [NUM_PORTS*BE_W-1:0]   p_be;
  logic [NUM_PORTS*DATA_W-1:0] p_wdata;
  logic [NUM_PORTS-1:0]        p_ready;
  logic [DATA_W-1:0]           p_rdata;
  logic [NUM_PORTS-1:0]        p_rdata_valid;

  logic [ADDR_W-1:0]           local_address;
  logic                        local_read_req;
  logic                        local_write_req;
  logic                        local_burstbegin;
  logic [SIZE_W-1:0]           local_size;
  logic [BE_W-1:0]             local_be;
  logic [DATA_W-1:0]           local_wdata;
  logic                        local_ready;
  logic [DATA_W-1:0]           local_rdata;
  logic                        local_rdata_valid;
  logic                        local_init_done;

  // master: the surrounding system (user masters plus controller)
  modport master (
    output p_address, p_read_req, p_write_req, p_burstbegin, p_size, p_be, p_wdata,
    input  p_ready, p_rdata, p_rdata_valid,
    input  local_address, local_read_req, local_write_req, local_burstbegin,
    input  local_size, local_be, local_wdata,
    output local_ready, local_rdata, local_rdata_valid, local_init_done
  );

  // slave: the arbiter itself
  modport slave (
    input  p_address, p_read_req, p_write_req, p_burstbegin, p_size, p_be, p_wdata,
    output p_ready, p_rdata, p_rdata_valid,
    output local_address, local_read_req, local_write_req, local_burstbegin,
    output local_size, local_be, local_wdata,
    input  local_ready, local_rdata, local_rdata_valid, local_init_done
  );
endinterface

// File: rtl/ddr2_local_port_arbiter.sv
// rtl/ddr2_local_port_arbiter.sv - N-port round-robin arbiter onto the DDR2 local port with read-return routing
// Optional: DDR2_ARB_PORT0_PRIORITY_EN gives port 0 absolute priority in IDLE.
module ddr2_local_port_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 64,
  parameter int BE_W      = 8,
  parameter int SIZE_W    = 4,
  parameter int RDQ_DEPTH = 16
) (
  input  logic                     phy_clk,
  input  logic                     reset_phy_clk_n,
  ddr2_local_port_arbiter_if.slave bus,
  output logic                     err_orphan_rdata
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW = $clog2(RDQ_DEPTH);

  typedef enum logic {IDLE, WBURST} state_t;

  state_t              state;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       lock_port;
  logic [SIZE_W-1:0]   beats_left;
  logic [NUM_PORTS-1:0] eligible;
  logic [PW-1:0]       rr_grant, grant, next_ptr;
  logic                rr_vld, grant_vld, advance;
  logic [SIZE_W-1:0]   size_eff;

  logic [PW-1:0]       tag_port [RDQ_DEPTH];
  logic [SIZE_W-1:0]   tag_size [RDQ_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         rdq_count;
  logic                rdq_full, rdq_empty, push, pop, ret_vld;
  logic [SIZE_W-1:0]   ret_cnt;

  assign rdq_full  = (rdq_count == (AW+1)'(RDQ_DEPTH));
  assign rdq_empty = (rdq_count == '0);

  // A read stalled on a full tag FIFO is simply not eligible, so writers behind it still win.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      eligible[i] = bus.local_init_done & bus.p_burstbegin[i] &
                    (bus.p_read_req[i] ? !rdq_full : bus.p_write_req[i]);
  end

  always_comb begin
    rr_grant = '0;
    rr_vld   = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (eligible[(int'(rr_ptr) + k) % NUM_PORTS]) begin
        rr_grant = PW'((int'(rr_ptr) + k) % NUM_PORTS);
        rr_vld   = 1'b1;
      end
    end
  end

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    if (state == WBURST) begin
      grant     = lock_port;
      grant_vld = 1'b1;
    end else
`ifdef DDR2_ARB_PORT0_PRIORITY_EN
    if (eligible[0]) begin
      grant     = '0;
      grant_vld = 1'b1;
    end else
`endif
    begin
      grant     = rr_grant;
      grant_vld = rr_vld;
    end
  end

  always_comb begin
    next_ptr = (int'(grant) == NUM_PORTS - 1) ? '0 : grant + PW'(1);
`ifdef DDR2_ARB_PORT0_PRIORITY_EN
    advance  = (grant != '0);
`else
    advance  = 1'b1;
`endif
  end

  always_comb begin
    bus.p_ready          = '0;
    bus.local_address    = '0;
    bus.local_read_req   = 1'b0;
    bus.local_write_req  = 1'b0;
    bus.local_burstbegin = 1'b0;
    bus.local_size       = '0;
    bus.local_be         = '0;
    bus.local_wdata      = '0;
    if (grant_vld) begin
      bus.local_address = bus.p_address[grant*ADDR_W +: ADDR_W];
      bus.local_size    = bus.p_size[grant*SIZE_W +: SIZE_W];
      bus.local_be      = bus.p_be[grant*BE_W +: BE_W];
      bus.local_wdata   = bus.p_wdata[grant*DATA_W +: DATA_W];
      if (state == WBURST) begin
        bus.local_write_req  = bus.p_write_req[grant];
        bus.local_burstbegin = bus.p_burstbegin[grant];
      end else begin
        bus.local_read_req   = bus.p_read_req[grant];
        bus.local_write_req  = !bus.p_read_req[grant];
        bus.local_burstbegin = 1'b1;
      end
      bus.p_ready[grant] = bus.local_ready & !(bus.local_read_req & rdq_full);
    end
  end

  assign size_eff = (bus.local_size == '0) ? SIZE_W'(1) : bus.local_size;
  assign push     = (state == IDLE) & grant_vld & bus.local_read_req & bus.local_ready & !rdq_full;
  assign ret_vld  = bus.local_rdata_valid & !rdq_empty;
  assign pop      = ret_vld & (ret_cnt == tag_size[rd_ptr] - SIZE_W'(1));

  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      lock_port  <= '0;
      beats_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld && bus.local_ready) begin
            if (bus.local_write_req && size_eff > SIZE_W'(1)) begin
              state      <= WBURST;
              lock_port  <= grant;
              beats_left <= size_eff - SIZE_W'(1);
            end else if (advance) begin
              rr_ptr <= next_ptr;
            end
          end
        end
        WBURST: begin
          if (bus.local_ready && bus.local_write_req) begin
            if (beats_left == SIZE_W'(1)) begin
              state      <= IDLE;
              beats_left <= '0;
              if (advance) rr_ptr <= next_ptr;
            end else begin
              beats_left <= beats_left - SIZE_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge phy_clk) begin
    if (push) begin
      tag_port[wr_ptr] <= grant;
      tag_size[wr_ptr] <= size_eff;
    end
  end

  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      rdq_count        <= '0;
      ret_cnt          <= '0;
      err_orphan_rdata <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   rdq_count <= rdq_count + (AW+1)'(1);
        2'b01:   rdq_count <= rdq_count - (AW+1)'(1);
        default: rdq_count <= rdq_count;
      endcase
      if (pop)          ret_cnt <= '0;
      else if (ret_vld) ret_cnt <= ret_cnt + SIZE_W'(1);
      if (bus.local_rdata_valid && rdq_empty) err_orphan_rdata <= 1'b1;
    end
  end

  assign bus.p_rdata = bus.local_rdata;

  always_comb begin
    bus.p_rdata_valid = '0;
    if (ret_vld) bus.p_rdata_valid[tag_port[rd_ptr]] = 1'b1;
  end
endmodule

// File: tb/tb_ddr2_local_port_arbiter.sv
// tb/tb_ddr2_local_port_arbiter.sv - directed self-checking bench for ddr2_local_port_arbiter
module tb_ddr2_local_port_arbiter;
  localparam int NP = 4, AW = 24, DW = 64, BW = 8, SW = 4, DEPTH = 16;

  logic phy_clk = 1'b0;
  logic reset_phy_clk_n;
  logic err_orphan_rdata;
  int   tests  = 0;
  int   failed = 0;

  ddr2_local_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .SIZE_W(SW)) bus();

  ddr2_local_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .SIZE_W(SW), .RDQ_DEPTH(DEPTH)
  ) dut (
    .phy_clk          (phy_clk),
    .reset_phy_clk_n  (reset_phy_clk_n),
    .bus              (bus),
    .err_orphan_rdata (err_orphan_rdata)
  );

  always #5 phy_clk = ~phy_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge phy_clk);
    #1;
  endtask

  task automatic req(input int p, input bit rd, input logic [SW-1:0] sz);
    bus.p_read_req[p]           = rd;
    bus.p_write_req[p]          = !rd;
    bus.p_burstbegin[p]         = 1'b1;
    bus.p_size[p*SW +: SW]      = sz;
  endtask

  task automatic drop(input int p);
    bus.p_read_req[p]   = 1'b0;
    bus.p_write_req[p]  = 1'b0;
    bus.p_burstbegin[p] = 1'b0;
  endtask

  logic [4:0]    rdy_pat = 5'b11101;
  logic [NP-1:0] bst_exp [5] = '{4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0100};
  logic [NP-1:0] rv_exp  [4] = '{4'b0010, 4'b0010, 4'b1000, 4'b1000};
`ifdef DDR2_ARB_PORT0_PRIORITY_EN
  logic [NP-1:0] pri_exp [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
  logic [NP-1:0] pri_exp [4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif

  initial begin
    int beat;
    reset_phy_clk_n       = 1'b0;
    bus.p_read_req        = '0;
    bus.p_write_req       = '0;
    bus.p_burstbegin      = '0;
    bus.p_size            = '0;
    bus.p_be              = '1;
    bus.local_ready       = 1'b0;
    bus.local_rdata       = '0;
    bus.local_rdata_valid = 1'b0;
    bus.local_init_done   = 1'b0;
    for (int i = 0; i < NP; i++) begin
      bus.p_address[i*AW +: AW] = AW'(24'h100 * (i + 1));
      bus.p_wdata[i*DW +: DW]   = 64'hD0 + 64'(i);
    end
    cyc();
    cyc();
    chk("rst_p_ready", 64'(bus.p_ready), 64'h0);
    chk("rst_rd_req", 64'(bus.local_read_req), 64'h0);
    chk("rst_wr_req", 64'(bus.local_write_req), 64'h0);
    chk("rst_addr", 64'(bus.local_address), 64'h0);
    chk("rst_rvalid", 64'(bus.p_rdata_valid), 64'h0);
    chk("rst_err", 64'(err_orphan_rdata), 64'h0);
    reset_phy_clk_n = 1'b1;
    cyc();

    // no grants before calibration completes
    req(0, 1'b0, 4'd1);
    bus.local_ready = 1'b1;
    #1;
    chk("noinit_wr_req", 64'(bus.local_write_req), 64'h0);
    chk("noinit_p_ready", 64'(bus.p_ready), 64'h0);
    cyc();
    bus.local_init_done = 1'b1;

    // four simultaneous single writes served in order
    req(1, 1'b0, 4'd1);
    req(2, 1'b0, 4'd1);
    req(3, 1'b0, 4'd1);
    for (int g = 0; g < NP; g++) begin
      #1;
      chk("rr_p_ready", 64'(bus.p_ready), 64'(1 << g));
      chk("rr_addr", 64'(bus.local_address), 64'(24'h100 * (g + 1)));
      chk("rr_wdata", bus.local_wdata, 64'hD0 + 64'(g));
      cyc();
      drop(g);
    end
    req(0, 1'b0, 4'd1);
    req(3, 1'b0, 4'd1);
    #1;
    chk("ptr_wrap_0", 64'(bus.p_ready), 64'h1);
    cyc();
    drop(0);
    #1;
    chk("ptr_wrap_3", 64'(bus.p_ready), 64'h8);
    cyc();
    drop(3);

    // move pointer to 2, then a 4-beat burst from port 2 against a waiting port 1
    req(1, 1'b0, 4'd1);
    #1;
    chk("pre_burst", 64'(bus.p_ready), 64'h2);
    cyc();
    drop(1);
    req(2, 1'b0, 4'd4);
    req(1, 1'b0, 4'd1);
    beat = 0;
    for (int c = 0; c < 5; c++) begin
      bus.local_ready = rdy_pat[c];
      bus.p_wdata[2*DW +: DW] = 64'h2000 + 64'(beat);
      #1;
      chk("burst_p_ready", 64'(bus.p_ready), 64'(bst_exp[c]));
      chk("burst_wdata", bus.local_wdata, 64'h2000 + 64'(beat));
      chk("burst_addr", 64'(bus.local_address), 64'h300);
      if (rdy_pat[c]) beat++;
      cyc();
      if (c == 0) bus.p_burstbegin[2] = 1'b0;
    end
    drop(2);
    #1;
    chk("after_burst", 64'(bus.p_ready), 64'h2);
    cyc();
    drop(1);

    // two 2-beat reads, returns routed back to the requesters
    req(1, 1'b1, 4'd2);
    #1;
    chk("rd1_p_ready", 64'(bus.p_ready), 64'h2);
    chk("rd1_rd_req", 64'(bus.local_read_req), 64'h1);
    cyc();
    drop(1);
    req(3, 1'b1, 4'd2);
    #1;
    chk("rd3_p_ready", 64'(bus.p_ready), 64'h8);
    cyc();
    drop(3);
    for (int k = 0; k < 4; k++) begin
      bus.local_rdata_valid = 1'b1;
      bus.local_rdata       = 64'hBEEF0 + 64'(k);
      #1;
      chk("ret_valid", 64'(bus.p_rdata_valid), 64'(rv_exp[k]));
      chk("ret_data", bus.p_rdata, 64'hBEEF0 + 64'(k));
      cyc();
    end
    bus.local_rdata_valid = 1'b0;

    // fill the tag FIFO and stall the 17th read
    req(0, 1'b1, 4'd1);
    for (int n = 0; n < DEPTH; n++) begin
      #1;
      chk("fill_p_ready", 64'(bus.p_ready), 64'h1);
      cyc();
    end
    #1;
    chk("full_p_ready", 64'(bus.p_ready), 64'h0);
    chk("full_rd_req", 64'(bus.local_read_req), 64'h0);
    req(2, 1'b0, 4'd1);
    #1;
    chk("full_wr_pass", 64'(bus.p_ready), 64'h4);
    cyc();
    drop(2);
    #1;
    chk("full_hold", 64'(bus.p_ready), 64'h0);
    bus.local_rdata_valid = 1'b1;
    #1;
    chk("full_pop_valid", 64'(bus.p_rdata_valid), 64'h1);
    chk("full_pop_ready", 64'(bus.p_ready), 64'h0);
    cyc();
    bus.local_rdata_valid = 1'b0;
    #1;
    chk("after_pop_ready", 64'(bus.p_ready), 64'h1);
    cyc();
    drop(0);
    for (int n = 0; n < DEPTH; n++) begin
      bus.local_rdata_valid = 1'b1;
      #1;
      chk("drain_valid", 64'(bus.p_rdata_valid), 64'h1);
      cyc();
    end
    bus.local_rdata_valid = 1'b0;

    // orphan read data
    #1;
    chk("orphan_pre", 64'(err_orphan_rdata), 64'h0);
    bus.local_rdata_valid = 1'b1;
    #1;
    chk("orphan_valid", 64'(bus.p_rdata_valid), 64'h0);
    cyc();
    bus.local_rdata_valid = 1'b0;
    #1;
    chk("orphan_err", 64'(err_orphan_rdata), 64'h1);
    cyc();
    cyc();
    cyc();
    chk("orphan_sticky", 64'(err_orphan_rdata), 64'h1);
    reset_phy_clk_n = 1'b0;
    #1;
    chk("orphan_clear", 64'(err_orphan_rdata), 64'h0);
    cyc();
    reset_phy_clk_n = 1'b1;
    cyc();

    // ports 0 and 1 requesting continuously
    req(0, 1'b0, 4'd1);
    req(1, 1'b0, 4'd1);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("pri_grant", 64'(bus.p_ready), 64'(pri_exp[c]));
      cyc();
    end
    drop(0);
    drop(1);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/ddr2_local_port_arbiter.md
Name: ddr2_local_port_arbiter

Overview:
- Multi-port front end for the DDR2 controller local interface. Sits between NUM_PORTS user masters and one controller local port, in the phy_clk domain.
- Uses round-robin arbitration. Write bursts are issued atomically.
- Outstanding reads are tracked in a tag FIFO so returned read data is routed back to the port that requested it.
- Generalises the single-master local interface to N channels and adds read-return routing.

Parameters:
- NUM_PORTS, 4, number of master ports (2..8).
- ADDR_W, 24, local address width.
- DATA_W, 64, local data width.
- BE_W, 8, byte-enable width (DATA_W/8).
- SIZE_W, 4, burst-size width.
- RDQ_DEPTH, 16, maximum outstanding read bursts (power of 2).

Ports:
- phy_clk  in  1  clock.
- reset_phy_clk_n  in  1  asynchronous active-low reset.
- p_address  in  NUM_PORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W].
- p_read_req  in  NUM_PORTS  per-port read request.
- p_write_req  in  NUM_PORTS  per-port write request.
- p_burstbegin  in  NUM_PORTS  first beat of a burst.
- p_size  in  NUM_PORTS*SIZE_W  burst length in beats.
- p_be  in  NUM_PORTS*BE_W  write byte enables.
- p_wdata  in  NUM_PORTS*DATA_W  write data.
- p_ready  out  NUM_PORTS  per-port accept.
- p_rdata  out  DATA_W  read data, broadcast to all ports.
- p_rdata_valid  out  NUM_PORTS  one-hot read-data valid.
- local_address / local_read_req / local_write_req / local_burstbegin / local_size / local_be / local_wdata  out  matching widths  to controller.
- local_ready  in  1  controller accept.
- local_rdata  in  DATA_W  controller read data.
- local_rdata_valid  in  1  controller read-data valid.
- local_init_done  in  1  calibration complete.
- err_orphan_rdata  out  1  sticky error flag.

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - Round-robin pointer = 0; tag FIFO empty; beat counters 0.
  - Reset asserted mid-burst aborts the burst immediately. No recovery of in-flight reads.
- Port eligibility: a port is eligible when (p_read_req | p_write_req) & p_burstbegin. Nothing is granted while local_init_done = 0.
- IDLE:
  - Pick the first eligible port at or after the pointer, wrapping modulo NUM_PORTS. Grant is combinational in the same cycle.
  - The granted port's command is muxed onto local_*.
  - p_ready[g] = local_ready, or local_ready & !rdq_full for reads. All other p_ready bits are 0.
- Read accept (local_ready & granted read & !rdq_full):
  - Push {port index, size} into the tag FIFO.
  - Pointer = g+1 (wraps). Stay in IDLE.
  - Reads are single-beat commands.
- Read stall: if the tag FIFO is full, local_read_req is held 0 and the port waits. Other ports' writes may still be granted.
- Write accept of the first beat:
  - If size > 1: enter WBURST and latch g and beats remaining = size-1.
  - If size = 1: the command completes; pointer = g+1.
- WBURST:
  - Grant is locked to the latched port; other requests are ignored.
  - Each beat accepted with local_ready decrements the counter.
  - The final beat returns to IDLE and sets pointer = g+1.
- Size 0 is treated as 1.
- Read return:
  - p_rdata = local_rdata, passed through combinationally.
  - p_rdata_valid[head.port] = local_rdata_valid.
  - A return beat counter increments per valid beat. The FIFO pops on beat head.size, and the counter clears.
- Simultaneous push and pop: both occur; occupancy is unchanged.
- Full/empty: full when occupancy = RDQ_DEPTH. A push while full cannot occur (gated).
- Orphan read data: local_rdata_valid while the FIFO is empty is dropped (p_rdata_valid = 0) and sets err_orphan_rdata. The flag clears only on reset.

Optional Feature:
- DDR2_ARB_PORT0_PRIORITY_EN defined:
  - In IDLE, an eligible port 0 wins over round-robin. The pointer is not advanced by port-0 grants.
  - A locked WBURST is never pre-empted.
- Not defined: pure round-robin for all ports.

Test Plan:
- Ports 0..3 each issue a size-1 write in the same cycle, local_ready = 1 -> grants in order 0,1,2,3 on consecutive cycles; pointer ends at 0.
- Port 2 issues a size-4 write while port 1 requests throughout, local_ready toggling 1,0,1,1,1 -> 4 beats from port 2 complete, then port 1 is granted; no interleaving.
- Ports 1 and 3 each issue a size-2 read, controller returns 4 valid beats -> p_rdata_valid = 0010,0010,1000,1000 in that order.
- RDQ_DEPTH = 16, 17 reads issued with no return -> the 17th is held with p_ready = 0 until the first return burst pops, then accepted the next cycle.
- local_rdata_valid pulsed with no reads outstanding -> no p_rdata_valid; err_orphan_rdata = 1 and remains 1 until reset.
- With DDR2_ARB_PORT0_PRIORITY_EN, ports 0 and 1 request continuously -> port 0 is always granted. Without the macro -> grants alternate 0,1,0,1.
